// File: rtl/data_mem.sv
// data_mem: byte-addressable little-endian data memory for the RV32IM
// memory stage. Each load/store takes a fixed number of busy cycles; the
// pipeline stalls while busywait is high.
//
// Handshake: the CPU raises a request (read[3] or write[2]) and holds it.
// busywait = req & ~ack is combinational, so the CPU stalls in the same
// cycle it asks. The access completes at the edge ending the last busy
// cycle; the following cycle is the ack cycle, where busywait is low and
// the CPU advances. A request still present in the ack cycle is treated
// as the old one and is not restarted.
module data_mem #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  read,
    input  logic [2:0]  write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic        dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            r_ack;
    logic            w_ack_next;
    logic            w_start;
    logic            w_done;

    // Byte storage
    logic [7:0]      r_mem [DEPTH];

    // Latched request
    logic            r_store;
    logic [2:0]      r_f3;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;

    // Request decode
    logic            w_req;
    logic            w_store;
    logic [2:0]      w_f3;
    logic [AW-1:0]   w_addr_eff;

    // Load path
    logic [AW-1:0]   w_a1;
    logic [AW-1:0]   w_a2;
    logic [AW-1:0]   w_a3;
    logic [7:0]      w_b0;
    logic [7:0]      w_b1;
    logic [7:0]      w_b2;
    logic [7:0]      w_b3;
    logic [31:0]     w_load_data;

    assign w_req     = read[3] | write[2];
    assign busywait  = w_req & ~r_ack;
    assign dbg_state = r_state;

    // A store wins when both enables are set, so its width code is used.
    assign w_store = write[2];
    assign w_f3    = write[2] ? {1'b0, write[1:0]} : read[2:0];

    // Wrap to the array and force natural alignment: f3[1:0] selects the size
    // (00 byte, 01 halfword, 1x word) for both loads and stores.
    always_comb begin
        w_addr_eff = address[AW-1:0];
        case (w_f3[1:0])
            2'b00:   w_addr_eff = address[AW-1:0];
            2'b01:   w_addr_eff[0] = 1'b0;
            default: w_addr_eff[1:0] = 2'b00;
        endcase
    end

    // Next-state logic: count busy cycles and raise ack for one cycle on completion.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ack_next   = 1'b0;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && !r_ack) begin
                    w_start      = 1'b1;
                    w_cnt_next   = CW'(1);
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == CW'(LATENCY - 1)) begin
                    w_done       = 1'b1;
                    w_ack_next   = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, counter and ack registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= w_ack_next;
        end
    end

    // Capture the request when an access starts; inputs are ignored afterwards.
    always_ff @(posedge clock) begin
        if (w_start) begin
            r_store <= w_store;
            r_f3    <= w_f3;
            r_addr  <= w_addr_eff;
            r_wdata <= writedata;
        end
    end

    // Little-endian byte gather; the aligned base keeps all bytes in range.
    assign w_a1 = r_addr + AW'(1);
    assign w_a2 = r_addr + AW'(2);
    assign w_a3 = r_addr + AW'(3);
    assign w_b0 = r_mem[r_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    // Size and sign/zero extension of the load result.
    always_comb begin
        w_load_data = {w_b3, w_b2, w_b1, w_b0};
        case (r_f3)
            3'b000:  w_load_data = {{24{w_b0[7]}}, w_b0};
            3'b001:  w_load_data = {{16{w_b1[7]}}, w_b1, w_b0};
            3'b100:  w_load_data = {24'h0, w_b0};
            3'b101:  w_load_data = {16'h0, w_b1, w_b0};
            default: w_load_data = {w_b3, w_b2, w_b1, w_b0};
        endcase
    end

    // Perform the latched access on completion; reset clears memory and readdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            readdata <= 32'h0;
        end else if (w_done) begin
            if (r_store) begin
                r_mem[r_addr] <= r_wdata[7:0];
                if (r_f3[1:0] != 2'b00) begin
                    r_mem[w_a1] <= r_wdata[15:8];
                end
                if (r_f3[1]) begin
                    r_mem[w_a2] <= r_wdata[23:16];
                    r_mem[w_a3] <= r_wdata[31:24];
                end
            end else begin
                readdata <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed test-plan sequences plus randomized loads and
// stores, checked against a byte-array reference model through a scoreboard.
module tb_data_mem;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  read;
    logic [2:0]  write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    logic        dbg_state;

    data_mem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    // Reference model
    logic [7:0]  model_mem [DEPTH];
    logic [31:0] model_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_rd = 32'h0;
    endfunction

    // Apply one request to the model: size from funct3[1:0], aligned base
    // taken modulo DEPTH, little-endian byte order.
    function automatic void model_op(input logic [3:0] rd, input logic [2:0] wr,
                                     input logic [31:0] addr, input logic [31:0] wd);
        logic [2:0]  f;
        int unsigned nbytes;
        int unsigned base;
        logic [31:0] val;
        f = wr[2] ? {1'b0, wr[1:0]} : rd[2:0];
        nbytes = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        base = ((addr / nbytes) * nbytes) % DEPTH;
        if (wr[2]) begin
            for (int i = 0; i < int'(nbytes); i++)
                model_mem[(base + i) % DEPTH] = 8'(wd >> (8 * i));
        end else if (rd[3]) begin
            val = 32'h0;
            for (int i = 0; i < int'(nbytes); i++)
                val = val | (32'(model_mem[(base + i) % DEPTH]) << (8 * i));
            if (nbytes < 4 && f[2] == 1'b0 && val[8 * nbytes - 1])
                val = val | (32'hFFFF_FFFF << (8 * nbytes));
            model_rd = val;
        end
    endfunction

    // Monitor: in the ack cycle (request present, busywait low) compare readdata.
    always @(negedge clock) begin
        if (!reset && (read[3] || write[2]) && !busywait) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_ack: got readdata 0x%08h with no pending request at %0t",
                         readdata, $time);
            end else begin
                check("sb_readdata", readdata, exp_q.pop_front());
            end
        end
    end

    // Driver: present a request, count busy cycles, drop it after the ack cycle.
    // Called just after a rising edge.
    task automatic do_req(input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        int busy;
        bit done;
        model_op(rd, wr, addr, wd);
        exp_q.push_back(model_rd);
        read      = rd;
        write     = wr;
        address   = addr;
        writedata = wd;
        busy = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (busywait) busy++;
            else done = 1;
        end
        if (!done) check("busy_timeout", 32'(busy), 32'(LATENCY));
        check("busy_cycles", 32'(busy), 32'(LATENCY));
        @(posedge clock);
        #1;
        read  = 4'b0;
        write = 3'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic [31:0] saved;
        reset = 1'b1;
        read = 4'b0;
        write = 3'b0;
        address = 32'h0;
        writedata = 32'h0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_readdata", readdata, 32'h0);
        check("reset_busywait_noreq", 32'(busywait), 32'h0);
        check("reset_state", 32'(dbg_state), 32'h0);
        read = 4'b1010;
        #1;
        check("reset_busywait_req", 32'(busywait), 32'h1);
        read = 4'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);

        // SW / LW
        do_req(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF);
        do_req(4'b1010, 3'b000, 32'h10, 32'h0);
        check("lw_0x10", readdata, 32'hDEADBEEF);

        // Byte and halfword extension
        do_req(4'b0000, 3'b110, 32'h20, 32'h80F17F82);
        do_req(4'b1000, 3'b000, 32'h20, 32'h0);
        check("lb_0x20", readdata, 32'hFFFFFF82);
        do_req(4'b1100, 3'b000, 32'h20, 32'h0);
        check("lbu_0x20", readdata, 32'h00000082);
        do_req(4'b1001, 3'b000, 32'h22, 32'h0);
        check("lh_0x22", readdata, 32'hFFFF80F1);
        do_req(4'b1101, 3'b000, 32'h22, 32'h0);
        check("lhu_0x22", readdata, 32'h000080F1);
        do_req(4'b1000, 3'b000, 32'h23, 32'h0);
        check("lb_0x23", readdata, 32'hFFFFFF80);

        // Partial stores
        do_req(4'b0000, 3'b110, 32'h30, 32'h11223344);
        do_req(4'b0000, 3'b100, 32'h31, 32'h000000AA);
        do_req(4'b0000, 3'b101, 32'h32, 32'h0000BEEF);
        do_req(4'b1010, 3'b000, 32'h30, 32'h0);
        check("partial_store", readdata, 32'hBEEFAA44);

        // Alignment and wrap
        do_req(4'b0000, 3'b110, 32'h43, 32'hCAFEBABE);
        do_req(4'b1010, 3'b000, 32'h40, 32'h0);
        check("lw_aligned", readdata, 32'hCAFEBABE);
        do_req(4'b1010, 3'b000, 32'(DEPTH) + 32'h40, 32'h0);
        check("lw_wrapped", readdata, 32'hCAFEBABE);

        // Back-to-back: load held through its ack cycle, then an immediate store
        do_req(4'b1010, 3'b000, 32'h10, 32'h0);
        do_req(4'b0000, 3'b110, 32'h60, 32'h13579BDF);
        do_req(4'b1010, 3'b000, 32'h60, 32'h0);
        check("b2b_store", readdata, 32'h13579BDF);

        // Both enables: store happens, readdata holds
        saved = 32'h13579BDF;
        do_req(4'b1010, 3'b110, 32'h64, 32'h5555AAAA);
        check("both_hold", readdata, saved);
        do_req(4'b1010, 3'b000, 32'h64, 32'h0);
        check("both_store", readdata, 32'h5555AAAA);

        // Reset in the 2nd busy cycle of a store
        do_req(4'b0000, 3'b110, 32'h50, 32'h0BADF00D);
        idle(1);
        read = 4'b0;
        write = 3'b110;
        address = 32'h50;
        writedata = 32'h12345678;
        @(negedge clock);
        check("abort_busy1", 32'(busywait), 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        write = 3'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check("abort_readdata", readdata, 32'h0);
        idle(LATENCY + 1);
        do_req(4'b1010, 3'b000, 32'h50, 32'h0);
        check("abort_lw_0x50", readdata, 32'h0);

        // Randomized traffic, wrapping addresses included
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5)
                do_req({1'b1, 3'($urandom_range(0, 7))}, 3'b000,
                       32'($urandom_range(0, 2 * DEPTH - 1)), 32'h0);
            else if (kind < 9)
                do_req(4'b0000, {1'b1, 2'($urandom_range(0, 3))},
                       32'($urandom_range(0, 2 * DEPTH - 1)), $urandom);
            else
                do_req({1'b1, 3'($urandom_range(0, 7))}, {1'b1, 2'($urandom_range(0, 3))},
                       32'($urandom_range(0, 2 * DEPTH - 1)), $urandom);
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
